pcs_rx_align_ctrl: RTL

Receive-side alignment controller for the 40GBASE-R PCS. It tracks the per-lane alignment-marker detections from the four alignment extractors and runs an alignment-marker lock state machine on each lane. Once all lanes are locked, it measures inter-lane skew and programs per-lane delay selects for the downstream deskew buffer. It also asserts `align_status`, which gates the descrambler output to the MAC, and keeps per-lane BIP error counts.

---
 rtl/pcs_pkg.sv | 21 ++
 rtl/am_lock_fsm.sv | 124 ++++++++++++
 rtl/pcs_rx_align_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared constants and state types for the 40GBASE-R receive alignment controller.
package pcs_pkg;

  localparam int NUM_LANES       = 4;
  localparam int AM_INTERVAL_DEF = 16384;
  localparam int MAX_MISS_DEF    = 4;
  localparam int MAX_SKEW_DEF    = 7;

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } am_lock_state_t;

  typedef enum logic [1:0] {
    WAIT,
    MEASURE,
    ALIGNED
  } align_state_t;

endpackage

// File: rtl/am_lock_fsm.sv
// One lane's alignment-marker lock: interval counter, miss counter, lock FSM and BIP error count.
// BIP checking and counting are built only when PCS_BIP_ERR_CNT_EN is defined.
module am_lock_fsm
  import pcs_pkg::*;
#(
  parameter int AM_INTERVAL = AM_INTERVAL_DEF,
  parameter int MAX_MISS    = MAX_MISS_DEF
) (
  input  logic        core_clk,
  input  logic        core_reset_n,
  input  logic        block_locked,
  input  logic        marker_detect,
  input  logic        bip_valid,
  output logic        am_lock,
  output logic        am_hit,
  output logic        lock_drop,
  output logic        bip_err,
  output logic [15:0] bip_err_count
);

  localparam int CNT_W  = $clog2(AM_INTERVAL + 1);
  localparam int MISS_W = $clog2(MAX_MISS + 1);

  am_lock_state_t    state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [MISS_W-1:0] miss, miss_nxt;
  logic              lock_nxt;
  logic              due;
  logic              bip_fail;

  assign due       = (cnt == CNT_W'(AM_INTERVAL));
  assign lock_drop = am_lock & ~lock_nxt;

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state   <= SEARCH;
      cnt     <= '0;
      miss    <= '0;
      am_lock <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      miss    <= miss_nxt;
      am_lock <= lock_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    miss_nxt  = miss;
    lock_nxt  = am_lock;
    am_hit    = 1'b0;
    bip_fail  = 1'b0;
    // Losing block lock overrides any marker seen in the same cycle.
    if (!block_locked) begin
      state_nxt = SEARCH;
      cnt_nxt   = '0;
      miss_nxt  = '0;
      lock_nxt  = 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (marker_detect) begin
            state_nxt = CHECK;
            cnt_nxt   = CNT_W'(1);
          end
        end
        CHECK: begin
          if (marker_detect) begin
            cnt_nxt = CNT_W'(1);
            if (due) begin
              state_nxt = LOCKED;
              lock_nxt  = 1'b1;
              miss_nxt  = '0;
            end
          end else if (due) begin
            state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          if (due) begin
            cnt_nxt = CNT_W'(1);
            if (marker_detect) begin
              am_hit   = 1'b1;
              miss_nxt = '0;
              bip_fail = ~bip_valid;
            end else if (miss == MISS_W'(MAX_MISS - 1)) begin
              state_nxt = SEARCH;
              lock_nxt  = 1'b0;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss + MISS_W'(1);
            end
          end
        end
        default: begin
          state_nxt = SEARCH;
          lock_nxt  = 1'b0;
        end
      endcase
    end
  end

`ifdef PCS_BIP_ERR_CNT_EN
  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      bip_err       <= 1'b0;
      bip_err_count <= '0;
    end else begin
      bip_err <= bip_fail;
      if (bip_fail && bip_err_count != 16'hFFFF) begin
        bip_err_count <= bip_err_count + 16'd1;
      end
    end
  end
`else
  logic unused_bip;
  assign unused_bip    = bip_fail;
  assign bip_err       = 1'b0;
  assign bip_err_count = '0;
`endif

endmodule

// File: rtl/pcs_rx_align_ctrl.sv
// 40GBASE-R receive alignment: four lane lock FSMs, skew measurement window and deskew delay selects.
// BIP error pulses/counters are present only when PCS_BIP_ERR_CNT_EN is defined.
module pcs_rx_align_ctrl
  import pcs_pkg::*;
#(
  parameter int  AM_INTERVAL = AM_INTERVAL_DEF,
  parameter int  MAX_MISS    = MAX_MISS_DEF,
  parameter int  MAX_SKEW    = MAX_SKEW_DEF,
  localparam int SKEW_W      = $clog2(MAX_SKEW + 1)
) (
  input  logic                        core_clk,
  input  logic                        core_reset_n,
  input  logic [NUM_LANES-1:0]        block_locked,
  input  logic [NUM_LANES-1:0]        marker_detect,
  input  logic [NUM_LANES-1:0]        bip_valid,
  output logic [NUM_LANES-1:0]        am_lock,
  output logic                        align_status,
  output logic [NUM_LANES*SKEW_W-1:0] lane_delay,
  output logic [NUM_LANES-1:0]        bip_err,
  output logic [NUM_LANES*16-1:0]     bip_err_count
);

  logic [NUM_LANES-1:0]        am_hit, lock_drop, arrived, arr_fin;
  logic [SKEW_W-1:0]           off_q   [NUM_LANES];
  logic [SKEW_W-1:0]           off_fin [NUM_LANES];
  logic [SKEW_W-1:0]           win_cnt, cur_off, max_off;
  logic [NUM_LANES*SKEW_W-1:0] dly_new, delay_nxt;
  logic                        win_open, active, closing, win_clr, status_nxt;
  align_state_t                astate, astate_nxt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    am_lock_fsm #(
      .AM_INTERVAL(AM_INTERVAL),
      .MAX_MISS   (MAX_MISS)
    ) u_lane (
      .core_clk     (core_clk),
      .core_reset_n (core_reset_n),
      .block_locked (block_locked[i]),
      .marker_detect(marker_detect[i]),
      .bip_valid    (bip_valid[i]),
      .am_lock      (am_lock[i]),
      .am_hit       (am_hit[i]),
      .lock_drop    (lock_drop[i]),
      .bip_err      (bip_err[i]),
      .bip_err_count(bip_err_count[i*16 +: 16])
    );
  end

  // Offset 0 is the cycle of the first marker in a round; hits on the closing cycle still count.
  always_comb begin
    cur_off = win_open ? win_cnt : '0;
    active  = win_open | (|am_hit);
    closing = active && (cur_off == SKEW_W'(MAX_SKEW));
    arr_fin = arrived | am_hit;
    max_off = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      off_fin[i] = arrived[i] ? off_q[i] : cur_off;
      if (off_fin[i] > max_off) max_off = off_fin[i];
    end
    dly_new = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      dly_new[i*SKEW_W +: SKEW_W] = max_off - off_fin[i];
    end
  end

  always_comb begin
    astate_nxt = astate;
    status_nxt = align_status;
    delay_nxt  = lane_delay;
    win_clr    = 1'b0;
    if (|lock_drop) begin
      astate_nxt = WAIT;
      status_nxt = 1'b0;
      delay_nxt  = '0;
      win_clr    = 1'b1;
    end else begin
      case (astate)
        WAIT: begin
          win_clr = 1'b1;
          if (&am_lock) astate_nxt = MEASURE;
        end
        MEASURE: begin
          if (closing && (&arr_fin)) begin
            astate_nxt = ALIGNED;
            status_nxt = 1'b1;
            delay_nxt  = dly_new;
          end
        end
        ALIGNED: begin
          // A failed re-measure keeps the old delays until the next successful round.
          if (closing && (!(&arr_fin) || dly_new != lane_delay)) begin
            astate_nxt = MEASURE;
            status_nxt = 1'b0;
          end
        end
        default: astate_nxt = WAIT;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      astate       <= WAIT;
      align_status <= 1'b0;
      lane_delay   <= '0;
    end else begin
      astate       <= astate_nxt;
      align_status <= status_nxt;
      lane_delay   <= delay_nxt;
    end
  end

  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      win_open <= 1'b0;
      win_cnt  <= '0;
      arrived  <= '0;
      for (int i = 0; i < NUM_LANES; i++) off_q[i] <= '0;
    end else if (win_clr || closing) begin
      win_open <= 1'b0;
      arrived  <= '0;
    end else if (active) begin
      win_open <= 1'b1;
      win_cnt  <= cur_off + SKEW_W'(1);
      arrived  <= arr_fin;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (am_hit[i] && !arrived[i]) off_q[i] <= cur_off;
      end
    end
  end

endmodule
